wb_uart_dbg_master: RTL and testbench

//  Serial debug initiator: decodes read/write commands from a UART line and issues single 32-bit

---
 rtl/dbg_bridge_pkg.sv | 12 +
 rtl/dbg_uart_phy.sv | 87 ++++++++
 rtl/wb_uart_dbg_master.sv | 134 +++++++++++++
 tb/tb_wb_uart_dbg_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bridge_pkg.sv
// dbg_bridge_pkg: command/status codes, FSM encoding and baud divisor helper for the UART debug master.
package dbg_bridge_pkg;
   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;
   localparam logic [7:0] ST_OK  = 8'hA5;
   localparam logic [7:0] ST_ERR = 8'hEE;
   localparam logic [7:0] ST_TMO = 8'hDD;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WB_REQ, S_RESP_STAT, S_RESP_DATA} state_t;
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction
endpackage

// File: rtl/dbg_uart_phy.sv
// dbg_uart_phy: 8N1 UART rx/tx bit engines, DIV clock cycles per bit.
module dbg_uart_phy #(
   parameter int DIV = 868
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rx_i,
   output logic       tx_o,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy
);
   localparam int CW = $clog2(DIV);
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   rx_state_t rx_state;
   logic [2:0] rx_sync;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic [2:0] rx_bit;
   logic [3:0] tx_bit;
   logic [8:0] tx_sh;
   // rx_sync[1] is the synchronized line, rx_sync[2] its previous value for edge detection
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         rx_sync  <= 3'b111;
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[1:0], rx_i};
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_cnt   <= rx_cnt + 1'b1;
         case (rx_state)
            R_IDLE: begin
               rx_cnt <= '0;
               if (rx_sync[2] && !rx_sync[1]) rx_state <= R_START;
            end
            R_START: if (rx_cnt == CW'(DIV / 2 - 1)) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_sync[1] ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt == CW'(DIV - 1)) begin
               rx_cnt  <= '0;
               rx_data <= {rx_sync[1], rx_data[7:1]};
               rx_bit  <= rx_bit + 1'b1;
               if (rx_bit == 3'd7) rx_state <= R_STOP;
            end
            R_STOP: if (rx_cnt == CW'(DIV - 1)) begin
               rx_valid <= rx_sync[1];
               rx_ferr  <= !rx_sync[1];
               rx_state <= R_IDLE;
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         tx_o    <= 1'b1;
         tx_busy <= 1'b0;
         tx_sh   <= '0;
         tx_cnt  <= '0;
         tx_bit  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            tx_o    <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_cnt  <= '0;
            tx_bit  <= '0;
         end
      end else if (tx_cnt != CW'(DIV - 1)) begin
         tx_cnt <= tx_cnt + 1'b1;
      end else begin
         tx_cnt  <= '0;
         tx_bit  <= tx_bit + 1'b1;
         tx_o    <= tx_bit == 4'd9 ? 1'b1 : tx_sh[0];
         tx_busy <= tx_bit != 4'd9;
         tx_sh   <= {1'b1, tx_sh[8:1]};
      end
endmodule

// File: rtl/wb_uart_dbg_master.sv
// wb_uart_dbg_master: UART command decoder issuing single Wishbone classic cycles and replying over UART.
// Define DBG_WB_TIMEOUT_EN to add a TIMEOUT_CYC bus watchdog (status 0xDD).
module wb_uart_dbg_master
   import dbg_bridge_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD        = 57600,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   output logic        busy_o
);
   state_t state;
   logic [7:0] rx_data, tx_data;
   logic rx_valid, rx_ferr, tx_start, tx_busy, is_wr, rd_ok, tmo_hit;
   logic [1:0] cnt;
   logic [31:0] rdata;
   dbg_uart_phy #(.DIV(calc_div(CLK_HZ, BAUD))) u_phy (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_i(uart_rx_i), .tx_o(uart_tx_o),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
   );
   assign busy_o = state != S_IDLE;
`ifdef DBG_WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] tmo_cnt;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) tmo_cnt <= '0;
      else tmo_cnt <= state != S_WB_REQ ? '0 : tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;
   assign tmo_hit = state == S_WB_REQ && tmo_cnt == TW'(TIMEOUT_CYC - 1);
`else
   assign tmo_hit = TIMEOUT_CYC < 0;
`endif
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state    <= S_IDLE;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wb_we_o  <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         is_wr    <= 1'b0;
         rd_ok    <= 1'b0;
         cnt      <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            S_IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
               is_wr <= rx_data == CMD_WR;
               cnt   <= '0;
               state <= S_ADDR;
            end
            S_ADDR: if (rx_ferr) state <= S_IDLE;
            else if (rx_valid) begin
               cnt      <= cnt + 1'b1;
               wb_adr_o <= {wb_adr_o[23:0], cnt == 2'd3 ? {rx_data[7:2], 2'b00} : rx_data};
               if (cnt == 2'd3 && is_wr) state <= S_WDATA;
               else if (cnt == 2'd3) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_sel_o <= 4'hF;
                  wb_we_o  <= 1'b0;
                  state    <= S_WB_REQ;
               end
            end
            S_WDATA: if (rx_ferr) state <= S_IDLE;
            else if (rx_valid) begin
               cnt      <= cnt + 1'b1;
               wb_dat_o <= {wb_dat_o[23:0], rx_data};
               if (cnt == 2'd3) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_sel_o <= 4'hF;
                  wb_we_o  <= 1'b1;
                  state    <= S_WB_REQ;
               end
            end
            // err outranks ack; the status byte leaves on the terminating edge
            S_WB_REQ: if (tmo_hit || (wb_cyc_o && (wb_ack_i || wb_err_i))) begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               wb_we_o  <= 1'b0;
               wb_sel_o <= '0;
               tx_start <= 1'b1;
               tx_data  <= wb_cyc_o && wb_err_i ? ST_ERR : wb_cyc_o && wb_ack_i ? ST_OK : ST_TMO;
               rd_ok    <= !is_wr && wb_cyc_o && wb_ack_i && !wb_err_i;
               rdata    <= wb_dat_i;
               state    <= S_RESP_STAT;
            end else begin
               wb_cyc_o <= !(wb_cyc_o && wb_rty_i);
               wb_stb_o <= !(wb_cyc_o && wb_rty_i);
            end
            S_RESP_STAT: begin
               tx_start <= 1'b0;
               if (!tx_start && !tx_busy && rd_ok) begin
                  tx_start <= 1'b1;
                  tx_data  <= rdata[31:24];
                  rdata    <= {rdata[23:0], 8'h00};
                  cnt      <= '0;
                  state    <= S_RESP_DATA;
               end else if (!tx_start && !tx_busy) state <= S_IDLE;
            end
            S_RESP_DATA: begin
               tx_start <= 1'b0;
               if (!tx_start && !tx_busy) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == 2'd3) state <= S_IDLE;
                  else begin
                     tx_start <= 1'b1;
                     tx_data  <= rdata[31:24];
                     rdata    <= {rdata[23:0], 8'h00};
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_wb_uart_dbg_master.sv
// tb_wb_uart_dbg_master: host UART driver/receiver, Wishbone slave model and response scoreboard.
module tb_wb_uart_dbg_master;
   localparam int DIV = 8;
   logic clk = 1'b0, rst_n_i = 1'b0, uart_rx_i = 1'b1, uart_tx_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
   logic [3:0] wb_sel_o;
   logic wb_we_o, wb_cyc_o, wb_stb_o, busy_o;
   logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   logic [7:0] exp_q[$], got_q[$];
   logic [7:0] rx_b;
   int n_cmp = 0, n_bad = 0, cyc_seen = 0;

   always #5 clk = ~clk;

   wb_uart_dbg_master #(.CLK_HZ(1_000_000), .BAUD(125_000), .TIMEOUT_CYC(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .busy_o(busy_o)
   );

   always @(posedge clk) if (wb_cyc_o) cyc_seen <= cyc_seen + 1;

   initial forever begin
      @(negedge uart_tx_o);
      repeat (DIV / 2) @(negedge clk);
      if (!uart_tx_o) begin
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            rx_b[i] = uart_tx_o;
         end
         repeat (DIV) @(negedge clk);
         got_q.push_back(rx_b);
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx_i = f[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx_i = 1'b1;
      if (!stop) repeat (2 * DIV) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] a, d;
      a = adr;
      d = dat;
      send_byte(op, 1'b1);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
      if (op == 8'h01) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
   endtask

   task automatic wb_slave(input int waits, input int mode, input int rtys,
                           output logic [31:0] adr, output logic [31:0] dat, output logic we,
                           output logic [3:0] sel, output int stbs, output int gaps,
                           output logic cyc_after);
      int n;
      stbs = 0; gaps = 0; cyc_after = 1'bx; adr = 'x; dat = 'x; we = 1'bx; sel = 'x;
      for (int r = 0; r <= rtys; r++) begin
         n = 0;
         while (!(wb_cyc_o && wb_stb_o) && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 3000) return;
         if (r > 0) gaps += n;
         stbs++;
         adr = wb_adr_o; dat = wb_dat_o; we = wb_we_o; sel = wb_sel_o;
         repeat (waits) @(negedge clk);
         wb_rty_i = r < rtys;
         wb_ack_i = r == rtys && mode != 1;
         wb_err_i = r == rtys && mode != 0;
         @(negedge clk);
         wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
         cyc_after = wb_cyc_o;
      end
   endtask

   task automatic wait_rx(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, wb_sel_o} !== 9'b1_0000_0000) begin
         n_bad++;
         $display("FAIL reset_ctl: got %b expected 100000000",
                  {uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, wb_sel_o});
      end
      n_cmp++;
      if ({wb_adr_o, wb_dat_o} !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_bus: got %h expected 0", {wb_adr_o, wb_dat_o});
      end
      rst_n_i = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_resp(input string name);
      bit ok;
      logic [7:0] e, g;
      wait_rx(exp_q.size(), ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_rx_timeout: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s_tx_byte: got %h expected %h", name, g, e);
         end
      end
      exp_q.delete();
      repeat (12 * DIV) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 0 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_trailing: got %0d extra bytes busy %b expected 0 and 0", name, got_q.size(), busy_o);
      end
      got_q.delete();
   endtask

   task automatic test_write;
      logic [31:0] adr, dat; logic we, ca; logic [3:0] sel; int stbs, gaps;
      exp_q.push_back(8'hA5);
      fork
         send_cmd(8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
         wb_slave(2, 0, 0, adr, dat, we, sel, stbs, gaps, ca);
      join
      n_cmp++;
      if ({stbs, adr, dat, we, sel, ca} !== {32'd1, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0}) begin
         n_bad++;
         $display("FAIL write_bus: got stbs %0d adr %h dat %h we %b sel %h cyc_after %b expected 1 10 deadbeef 1 f 0",
                  stbs, adr, dat, we, sel, ca);
      end
      check_resp("write");
   endtask

   task automatic test_read(input logic [31:0] a, input logic [31:0] d, input logic [31:0] ea);
      logic [31:0] adr, dat; logic we, ca; logic [3:0] sel; int stbs, gaps;
      wb_dat_i = d;
      exp_q.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
      fork
         send_cmd(8'h02, a, 32'h0);
         wb_slave(1, 0, 0, adr, dat, we, sel, stbs, gaps, ca);
      join
      n_cmp++;
      if ({stbs, adr, we, sel, ca} !== {32'd1, ea, 1'b0, 4'hF, 1'b0}) begin
         n_bad++;
         $display("FAIL read_bus: got stbs %0d adr %h we %b sel %h cyc_after %b expected 1 %h 0 f 0",
                  stbs, adr, we, sel, ca, ea);
      end
      check_resp("read");
   endtask

   task automatic test_err(input int mode);
      logic [31:0] adr, dat; logic we, ca; logic [3:0] sel; int stbs, gaps;
      wb_dat_i = 32'h1122_3344;
      exp_q.push_back(8'hEE);
      fork
         send_cmd(8'h02, 32'h0000_0020, 32'h0);
         wb_slave(0, mode, 0, adr, dat, we, sel, stbs, gaps, ca);
      join
      n_cmp++;
      if ({stbs, ca} !== {32'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL err_bus: got stbs %0d cyc_after %b expected 1 0", stbs, ca);
      end
      check_resp("err");
   endtask

   task automatic test_retry;
      logic [31:0] adr, dat; logic we, ca; logic [3:0] sel; int stbs, gaps;
      exp_q.push_back(8'hA5);
      fork
         send_cmd(8'h01, 32'h0000_0100, 32'hCAFE_F00D);
         wb_slave(0, 0, 2, adr, dat, we, sel, stbs, gaps, ca);
      join
      n_cmp++;
      if ({stbs, gaps, adr, dat, we} !== {32'd3, 32'd2, 32'h100, 32'hCAFEF00D, 1'b1}) begin
         n_bad++;
         $display("FAIL retry_bus: got stbs %0d gaps %0d adr %h dat %h we %b expected 3 2 100 cafef00d 1",
                  stbs, gaps, adr, dat, we);
      end
      check_resp("retry");
   endtask

   task automatic test_timeout;
      int n = 0, hi = 0;
      send_cmd(8'h02, 32'h0000_0040, 32'h0);
      while (!wb_cyc_o && n < 200) begin
         @(negedge clk);
         n++;
      end
`ifdef DBG_WB_TIMEOUT_EN
      exp_q.push_back(8'hDD);
      while (wb_cyc_o && hi < 100) begin
         @(negedge clk);
         hi++;
      end
      n_cmp++;
      if (hi != 16) begin
         n_bad++;
         $display("FAIL timeout_len: got %0d cycles expected 16", hi);
      end
      check_resp("timeout");
`else
      repeat (200) @(negedge clk);
      hi = 0;
      n_cmp++;
      if ({wb_cyc_o, busy_o, got_q.size() == 0} !== 3'b111) begin
         n_bad++;
         $display("FAIL no_timeout_hold: got cyc %b busy %b rx %0d expected 1 1 0", wb_cyc_o, busy_o, got_q.size());
      end
      rst_n_i = 1'b0;
      #1;
      n_cmp++;
      if ({wb_cyc_o, busy_o, uart_tx_o} !== 3'b001) begin
         n_bad++;
         $display("FAIL no_timeout_reset: got %b expected 001", {wb_cyc_o, busy_o, uart_tx_o});
      end
      @(negedge clk);
      rst_n_i = 1'b1;
      repeat (3) @(negedge clk);
`endif
   endtask

   task automatic test_ignore;
      int c0;
      c0 = cyc_seen;
      uart_rx_i = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx_i = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      send_byte(8'h7F, 1'b1);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b1);
      send_byte(8'h55, 1'b0);
      send_byte(8'h10, 1'b1);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ferr_idle: got busy %b expected 0", busy_o);
      end
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_addr_busy: got %b expected 1", busy_o);
      end
      rst_n_i = 1'b0;
      #1;
      n_cmp++;
      if ({busy_o, uart_tx_o, wb_cyc_o} !== 3'b010) begin
         n_bad++;
         $display("FAIL async_reset: got %b expected 010", {busy_o, uart_tx_o, wb_cyc_o});
      end
      @(negedge clk);
      rst_n_i = 1'b1;
      repeat (20 * DIV) @(negedge clk);
      n_cmp++;
      if ({cyc_seen == c0, got_q.size() == 0, busy_o} !== 3'b110) begin
         n_bad++;
         $display("FAIL ignore_quiet: got bus cycles %0d rx %0d busy %b expected 0 0 0",
                  cyc_seen - c0, got_q.size(), busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010);
      test_read(32'h1234_5677, 32'h0BAD_F00D, 32'h1234_5674);
      test_err(1);
      test_err(2);
      test_retry();
      test_timeout();
      test_ignore();
      test_read(32'h0000_0008, 32'h5A5A_0FF0, 32'h0000_0008);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
